gray_counter: RTL

Parametrised, registered Gray-code counter extending the team's combinational 4-bit binary-to-Gray converter into a sequential block. It holds a binary count, updates it on enable in a selectable direction, and supports parallel load in binary or Gray encoding, converting Gray to binary internally. Both encodings are output from registers. It is intended as the pointer or position source for clock-domain-crossing paths and for encoder and stepper logic elsewhere in the design.

---
 rtl/gray_counter.sv | 45 ++++
 1 files changed

// File: rtl/gray_counter.sv
// gray_counter: registered up/down counter exposing binary and Gray encodings,
// with parallel load in either encoding and a one-cycle boundary flag.
module gray_counter #(
  parameter int WIDTH = 4,
  parameter int WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] in_load,
  output logic [WIDTH-1:0] out_binary,
  output logic [WIDTH-1:0] out_gray,
  output logic             out_wrap
);
  logic [WIDTH-1:0] cnt_q, cnt_d, gray_q, gray_d, ld_bin, step;
  logic             wrap_q, wrap_d, bnd;
  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
  for (genvar i = 0; i < WIDTH; i++) begin : g_g2b
    assign ld_bin[i] = ^in_load[WIDTH-1:i];
  end
  always_comb begin
    bnd    = up_down ? &cnt_q : ~|cnt_q;
    step   = up_down ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
    cnt_d  = load ? (load_is_gray ? ld_bin : in_load)
           : (en && !(bnd && WRAP == 0)) ? step : cnt_q;
    gray_d = cnt_d ^ (cnt_d >> 1);
    wrap_d = !load && en && bnd;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  assign out_binary = cnt_q;
  assign out_gray   = gray_q;
  assign out_wrap   = wrap_q;
endmodule
